// File: rtl/multicycle_load_sequencer.sv
// Control FSM for the multi-cycle MIPS datapath: registered load strobes,
// memory handshake and datapath mux selects, one phase per state.
// Optional feature macro: SEQ_INSTR_CNT_EN adds a 32-bit retired-instruction counter.
module multicycle_load_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        alu_zero,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        load_pc,
    output logic        load_npc,
    output logic        load_ir,
    output logic        load_a,
    output logic        load_b,
    output logic        load_imm,
    output logic        load_alu,
    output logic        load_lmd,
    output logic [1:0]  pc_sel,
    output logic [1:0]  alu_op,
    output logic        alu_src_b,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        wb_sel,
    output logic        halted,
    output logic        error,
    output logic [2:0]  state
`ifdef SEQ_INSTR_CNT_EN
    ,
    output logic [31:0] instr_count
`endif
);

    localparam int unsigned WAIT_W = 8;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam logic [1:0] PC_NPC = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd7
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic       load_pc;
        logic       load_npc;
        logic       load_ir;
        logic       load_a;
        logic       load_b;
        logic       load_imm;
        logic       load_alu;
        logic       load_lmd;
        logic [1:0] pc_sel;
        logic [1:0] alu_op;
        logic       alu_src_b;
        logic       reg_write;
        logic       reg_dst;
        logic       wb_sel;
        logic       halted;
        logic       error;
    } ctl_t;

    state_t              cur_state, nxt_state;
    logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
    ctl_t                ctl, ctl_nxt;
    logic [1:0]          alu_op_c;
    logic                alu_src_b_c;
    logic                timeout_c;

    // Controls for entering FETCH: PC load with its source, next request raised.
    function automatic ctl_t fetch_ctl(input logic [1:0] sel);
        ctl_t c;
        c         = '0;
        c.load_pc = 1'b1;
        c.pc_sel  = sel;
        c.mem_req = 1'b1;
        return c;
    endfunction

    // ALU control decode for the instruction held in IR.
    always_comb begin
        alu_op_c    = 2'b00;
        alu_src_b_c = 1'b0;
        case (opcode)
            OP_R:                 begin alu_op_c = 2'b10; alu_src_b_c = 1'b0; end
            OP_ADDI, OP_LW, OP_SW: begin alu_op_c = 2'b00; alu_src_b_c = 1'b1; end
            OP_BEQ:               begin alu_op_c = 2'b01; alu_src_b_c = 1'b0; end
            default:              begin alu_op_c = 2'b00; alu_src_b_c = 1'b0; end
        endcase
    end

    assign timeout_c = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

    // Next state and next-cycle output values; strobes only on state entry.
    always_comb begin
        nxt_state = cur_state;
        wait_nxt  = wait_cnt;
        ctl_nxt   = '0;
        case (cur_state)
            S_IDLE: begin
                nxt_state       = S_FETCH;
                wait_nxt        = '0;
                ctl_nxt.mem_req = 1'b1;
            end
            S_FETCH: begin
                if (mem_ack) begin
                    nxt_state        = S_DECODE;
                    wait_nxt         = '0;
                    ctl_nxt.load_ir  = 1'b1;
                    ctl_nxt.load_npc = 1'b1;
                end else if (timeout_c) begin
                    nxt_state      = S_HALT;
                    wait_nxt       = '0;
                    ctl_nxt.halted = 1'b1;
                    ctl_nxt.error  = 1'b1;
                end else begin
                    wait_nxt        = wait_cnt + WAIT_W'(1);
                    ctl_nxt.mem_req = 1'b1;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_HALT: begin
                        nxt_state      = S_HALT;
                        ctl_nxt.halted = 1'b1;
                    end
                    OP_J: begin
                        nxt_state = S_FETCH;
                        wait_nxt  = '0;
                        ctl_nxt   = fetch_ctl(PC_JMP);
                    end
                    OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ: begin
                        nxt_state         = S_EXEC;
                        ctl_nxt.load_a    = 1'b1;
                        ctl_nxt.load_b    = 1'b1;
                        ctl_nxt.load_imm  = 1'b1;
                        ctl_nxt.alu_op    = alu_op_c;
                        ctl_nxt.alu_src_b = alu_src_b_c;
                    end
                    default: begin
                        nxt_state = S_FETCH;
                        wait_nxt  = '0;
                        ctl_nxt   = fetch_ctl(PC_NPC);
                    end
                endcase
            end
            S_EXEC: begin
                if (opcode == OP_BEQ) begin
                    nxt_state = S_FETCH;
                    wait_nxt  = '0;
                    ctl_nxt   = fetch_ctl(alu_zero ? PC_BR : PC_NPC);
                end else if (opcode == OP_LW || opcode == OP_SW) begin
                    // ALU controls stay stable while load_alu clocks ALUOut.
                    nxt_state         = S_MEM;
                    wait_nxt          = '0;
                    ctl_nxt.load_alu  = 1'b1;
                    ctl_nxt.mem_req   = 1'b1;
                    ctl_nxt.addr_sel  = 1'b1;
                    ctl_nxt.mem_we    = (opcode == OP_SW);
                    ctl_nxt.alu_op    = ctl.alu_op;
                    ctl_nxt.alu_src_b = ctl.alu_src_b;
                end else if (opcode == OP_R || opcode == OP_ADDI) begin
                    nxt_state         = S_WB;
                    ctl_nxt.load_alu  = 1'b1;
                    ctl_nxt.reg_write = 1'b1;
                    ctl_nxt.reg_dst   = (opcode == OP_R);
                    ctl_nxt.alu_op    = ctl.alu_op;
                    ctl_nxt.alu_src_b = ctl.alu_src_b;
                end else begin
                    nxt_state = S_FETCH;
                    wait_nxt  = '0;
                    ctl_nxt   = fetch_ctl(PC_NPC);
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    wait_nxt = '0;
                    if (opcode == OP_LW) begin
                        nxt_state         = S_WB;
                        ctl_nxt.load_lmd  = 1'b1;
                        ctl_nxt.reg_write = 1'b1;
                        ctl_nxt.wb_sel    = 1'b1;
                        ctl_nxt.alu_op    = ctl.alu_op;
                        ctl_nxt.alu_src_b = ctl.alu_src_b;
                    end else begin
                        nxt_state = S_FETCH;
                        ctl_nxt   = fetch_ctl(PC_NPC);
                    end
                end else if (timeout_c) begin
                    nxt_state      = S_HALT;
                    wait_nxt       = '0;
                    ctl_nxt.halted = 1'b1;
                    ctl_nxt.error  = 1'b1;
                end else begin
                    wait_nxt          = wait_cnt + WAIT_W'(1);
                    ctl_nxt.mem_req   = 1'b1;
                    ctl_nxt.addr_sel  = 1'b1;
                    ctl_nxt.mem_we    = ctl.mem_we;
                    ctl_nxt.alu_op    = ctl.alu_op;
                    ctl_nxt.alu_src_b = ctl.alu_src_b;
                end
            end
            S_WB: begin
                nxt_state = S_FETCH;
                wait_nxt  = '0;
                ctl_nxt   = fetch_ctl(PC_NPC);
            end
            S_HALT: begin
                nxt_state      = S_HALT;
                ctl_nxt.halted = 1'b1;
                ctl_nxt.error  = ctl.error;
            end
            default: begin
                nxt_state = S_IDLE;
                wait_nxt  = '0;
            end
        endcase
    end

    // State, wait counter and all outputs are flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state <= S_IDLE;
            wait_cnt  <= '0;
            ctl       <= '0;
        end else begin
            cur_state <= nxt_state;
            wait_cnt  <= wait_nxt;
            ctl       <= ctl_nxt;
        end
    end

`ifdef SEQ_INSTR_CNT_EN
    // Counts instructions retired back into FETCH; IDLE start and HALT excluded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_count <= '0;
        end else if (nxt_state == S_FETCH &&
                     (cur_state == S_DECODE || cur_state == S_EXEC ||
                      cur_state == S_MEM    || cur_state == S_WB)) begin
            instr_count <= instr_count + 32'd1;
        end
    end
`endif

    assign mem_req   = ctl.mem_req;
    assign mem_we    = ctl.mem_we;
    assign addr_sel  = ctl.addr_sel;
    assign load_pc   = ctl.load_pc;
    assign load_npc  = ctl.load_npc;
    assign load_ir   = ctl.load_ir;
    assign load_a    = ctl.load_a;
    assign load_b    = ctl.load_b;
    assign load_imm  = ctl.load_imm;
    assign load_alu  = ctl.load_alu;
    assign load_lmd  = ctl.load_lmd;
    assign pc_sel    = ctl.pc_sel;
    assign alu_op    = ctl.alu_op;
    assign alu_src_b = ctl.alu_src_b;
    assign reg_write = ctl.reg_write;
    assign reg_dst   = ctl.reg_dst;
    assign wb_sel    = ctl.wb_sel;
    assign halted    = ctl.halted;
    assign error     = ctl.error;
    assign state     = cur_state;

endmodule

// File: doc/multicycle_load_sequencer.md
# multicycle_load_sequencer

Control FSM for the multi-cycle MIPS datapath. Generates single-cycle load strobes for the edge-triggered datapath registers (PC, NPC, IR, A, B, Imm, ALUOut, LMD), the memory request handshake, and the datapath mux selects. It walks each instruction through FETCH, DECODE, EXEC, MEM and WB, and stops in HALT on a halt opcode or a memory timeout.

## Interface
- MEM_TIMEOUT, 15: maximum wait cycles (1..255) for mem_ack before error halt.
- clk  in  1  system clock; all state and outputs update on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26], valid from the cycle after load_ir.
- alu_zero  in  1  ALU zero flag, valid in EXEC.
- mem_ack  in  1  memory completion; memory holds read data stable for one cycle after the ack edge.
- mem_req, mem_we, addr_sel  out  1 each  request; write enable; 0 = PC address, 1 = ALUOut address.
- load_pc, load_npc, load_ir, load_a, load_b, load_imm, load_alu, load_lmd  out  1 each  register load strobes.
- pc_sel  out  2  00 = NPC, 01 = branch target, 10 = jump target.
- alu_op  out  2  00 = add, 01 = sub, 10 = use funct.
- alu_src_b, reg_write, reg_dst, wb_sel  out  1 each  0 = B / 1 = Imm; RF write; 1 = rd, 0 = rt; 1 = LMD, 0 = ALUOut.
- halted, error, state  out  1, 1, 3  status outputs.

## Operation
- Every output is a flip-flop output. Strobes drive register clock pins, so they must be glitch-free.
- Each load strobe is high for exactly one clk cycle: the first cycle of the state being entered.
- State encodings: IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, HALT = 7.
- IDLE → FETCH unconditionally.
- FETCH
  - Holds mem_req = 1, mem_we = 0, addr_sel = 0.
  - On mem_ack → DECODE, pulsing load_ir and load_npc.
- DECODE: branches on opcode.
  - 0x3F → HALT.
  - 0x02 (J) → FETCH, pulsing load_pc with pc_sel = 10.
  - 0x00 (R), 0x08 (ADDI), 0x23 (LW), 0x2B (SW), 0x04 (BEQ) → EXEC, pulsing load_a, load_b and load_imm.
  - Any other opcode → FETCH, pulsing load_pc with pc_sel = 00 (NOP).
- EXEC: alu_op / alu_src_b are R 10/0, ADDI 00/1, LW and SW 00/1, BEQ 01/0.
  - BEQ → FETCH, pulsing load_pc; pc_sel = 01 if alu_zero, else 00.
  - LW, SW → MEM, pulsing load_alu.
  - R, ADDI → WB, pulsing load_alu.
- MEM: mem_req = 1, addr_sel = 1, mem_we = 1 for SW.
  - On ack, LW → WB, pulsing load_lmd.
  - On ack, SW → FETCH, pulsing load_pc with pc_sel = 00.
- WB
  - reg_write = 1 for one cycle.
  - reg_dst = 1 for R-type.
  - wb_sel = 1 for LW.
  - Then → FETCH, pulsing load_pc with pc_sel = 00.
- HALT
  - halted = 1; all strobes and mem_req = 0.
  - Left only by reset.
- Timeout
  - A wait counter counts FETCH/MEM cycles with mem_ack low and clears on state entry.
  - If mem_ack is still low in wait cycle MEM_TIMEOUT → HALT with error = 1.
  - If ack arrives in that same cycle, ack wins and there is no error.

## Timing
- Reset (asynchronous): state = IDLE; every output = 0; wait counter = 0.
- The first rising edge after rst deasserts enters FETCH with mem_req = 1.
- mem_ack is sampled on the rising edge. mem_req drops in the cycle after the ack edge.
- load_pc and the next fetch's mem_req rise on the same edge. Memory must not ack before the following edge.
- Latency with zero-wait memory (ack on the first FETCH/MEM edge), cycles from FETCH entry to next FETCH entry: J 2, BEQ 3, NOP 2, R 4, ADDI 4, SW 4, LW 5. Each memory wait cycle adds 1.
- Reset asserted mid-instruction: immediate return to reset values. Any strobe already high falls with no new rising edge.

## Configuration
- SEQ_INSTR_CNT_EN defined: adds output instr_count (32 bits).
  - Resets to 0.
  - Increments on every FETCH entry from DECODE, EXEC, MEM or WB; wraps from 0xFFFFFFFF to 0.
  - HALT entries are not counted.
- SEQ_INSTR_CNT_EN undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- Reset then R-type (opcode 0x00), ack at the first FETCH edge → load_ir/load_npc, then load_a/b/imm, then load_alu, then reg_write = 1 with reg_dst = 1, then load_pc; FETCH to FETCH in 4 cycles.
- LW (0x23) with 3 wait cycles on the MEM ack → mem_req and addr_sel = 1 held for 4 cycles; load_lmd pulses once; wb_sel = 1 in WB; 8 cycles total.
- BEQ (0x04) with alu_zero = 1, then with alu_zero = 0 → load_pc with pc_sel = 01, then 00; 3 cycles each.
- mem_ack held low in FETCH, MEM_TIMEOUT = 4 → HALT after 4 wait cycles with error = 1, halted = 1, no strobes afterwards. Repeat with ack in wait cycle 4 → no error.
- Opcode 0x3F → HALT with error = 0. Opcode 0x11 → NOP, FETCH to FETCH in 2 cycles.
- Drop rst while in EXEC with load_a high → all outputs 0 immediately; restart fetches normally. With SEQ_INSTR_CNT_EN defined, instr_count returns to 0 and counts 3 after three instructions.
